uart_rx_cfg: RTL
================

# uart_rx_cfg

Parametrised 8-bit-and-beyond UART receiver: configurable data width, optional odd/even parity, one or two stop bits, input synchroniser, 3-sample majority voting and per-frame error reporting (parity, framing, break). It sits between the board RX pin and the byte-consuming logic. It replaces the fixed 8N1 receiver wherever line robustness or non-8N1 framing is needed. Each received frame is delivered as a one-cycle valid strobe with data and status.

## Interface
- CLKS_PER_BIT, 217, i_Clock cycles per bit (clock freq / baud); legal range 8..65535
- DATA_BITS, 8, data bits per frame; legal range 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- i_Clock  in  1  single clock; all logic on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_RX_Serial  in  1  asynchronous serial line, idle high
- o_RX_DV  out  1  one-cycle strobe: frame complete, data/status valid
- o_RX_Byte  out  DATA_BITS  received data, LSB = first bit on line
- o_Parity_Err  out  1  parity mismatch for the frame (always 0 when PARITY=0)
- o_Frame_Err  out  1  a stop bit sampled 0
- o_Break  out  1  data, parity and stop all sampled 0
- o_RX_Busy  out  1  high from start detection until return to IDLE

## Operation
- i_RX_Serial passes through a 2-flop synchroniser; both flops reset to 1. FSM uses only the synchronised line S.
- Bit counter width $clog2(CLKS_PER_BIT); runs 0..CLKS_PER_BIT-1 per bit, then wraps to 0 and advances the bit index. H = CLKS_PER_BIT/2 (integer).
- Per-bit value = majority of S at counts H-1, H, H+1; decided at count H+1.
- States: WAIT_HIGH, IDLE, START, DATA, PARITY, STOP.
- WAIT_HIGH: entered on reset. Goes to IDLE on the first cycle S=1.
- IDLE: S=0 -> START with count 0, busy=1.
- START: voted value 1 -> false start. Go to IDLE next cycle, no strobe, no flag change. Voted 0 -> continue to count C-1, then DATA.
- DATA: DATA_BITS bits shifted LSB-first. Then PARITY if PARITY!=0, else STOP.
- PARITY: one bit. Odd: ones(data)+parity must be odd. Even: must be even.
- STOP: STOP_BITS bits; any voted 0 sets frame error.
- At the decision point (H+1) of the final stop bit, the cycle after:
  - o_RX_DV=1 for exactly one cycle
  - o_RX_Byte and all three flags updated
  - FSM goes to IDLE if the final stop voted 1, else to WAIT_HIGH
  - Remaining half stop bit is not waited out, allowing back-to-back frames with clock skew.
- o_Break = frame error AND all data bits 0 AND (parity bit 0 or PARITY=0). o_Break implies o_Frame_Err.
- Data and flags hold their values between strobes. They change only at o_RX_DV.
- A frame with errors still delivers data with o_RX_DV=1.

## Timing
- Reset (any state, any cycle, mid-frame included): the next cycle has:
  - FSM in WAIT_HIGH
  - counters 0
  - o_RX_DV=0, o_RX_Byte=0, all flags 0, o_RX_Busy=0
  - synchroniser flops at 1
  - A partial frame is discarded.
- Let k = the clock edge that first samples i_RX_Serial low, and N = 1 + DATA_BITS + (PARITY!=0) + (STOP_BITS-1).
  - START count 0 is after edge k+2.
  - o_RX_DV is high in the cycle after edge k + N·CLKS_PER_BIT + H + 4.
- o_RX_Busy rises after edge k+2.
  - It falls with the FSM leaving STOP, or on a false start at START count H+2.
- Line low again while in IDLE the same cycle as return: start detected immediately; no dead cycle required.
- Glitch of 1 cycle during the start-bit vote window: rejected by majority; frame proceeds.

## Test plan
- CLKS_PER_BIT=16, 8N1, send 0xA5 then 0x3C back-to-back -> two strobes:
  - first 156 cycles after edge k, o_RX_Byte=0xA5
  - second 0x3C
  - all flags 0
- PARITY=2, DATA_BITS=7, send 0x55 with wrong parity bit 1 -> strobe, o_RX_Byte=0x55, o_Parity_Err=1; next frame with correct parity clears it.
- STOP_BITS=2, second stop driven 0 -> o_Frame_Err=1, o_Break=0. Line then held high -> FSM returns to IDLE.
- Break: line low for 3 frame times -> exactly one strobe with o_RX_Byte=0, o_Frame_Err=1, o_Break=1. No further strobes until the line is high and a new start bit arrives.
- False start: 4-cycle low pulse -> no strobe, o_RX_Busy high then low, flags unchanged.
- Single-cycle glitch at data bit 3 sample point H -> byte correct. i_Reset asserted mid-DATA -> all outputs 0 the next cycle, and no strobe for the aborted frame.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver.
// Supports a configurable data width, optional odd/even parity and one or two stop bits.
// The RX line is synchronised and each bit is decided by a 3-sample majority vote.
// Every frame produces a one-cycle strobe carrying the data and its parity, framing and break status.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_RX_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int H     = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_HM1  = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_H    = CNT_W'(H);
  localparam logic [CNT_W-1:0] CNT_HP1  = CNT_W'(H + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       IDX_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       IDX_STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_WAIT_HIGH,
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 r_state;
  logic                   r_sync1;
  logic                   r_sync2;
  logic [CNT_W-1:0]       r_cnt;
  logic [3:0]             r_idx;
  logic                   r_smp_a;
  logic                   r_smp_b;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_bit;
  logic                   r_ferr_acc;
  logic                   r_rx_dv;
  logic [DATA_BITS-1:0]   r_rx_byte;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_brk;
  logic                   r_busy;

  logic                   w_vote;
  logic                   w_sample_pt;
  logic                   w_bit_end;
  logic                   w_ferr_final;

  // Majority of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity mismatch for the configured parity mode; never set without parity.
  function automatic logic parity_err(input logic [DATA_BITS-1:0] d, input logic p);
    logic v;
    v = 1'b0;
    if (PARITY == 1) v = ~(^d ^ p);
    else if (PARITY == 2) v = ^d ^ p;
    return v;
  endfunction

  // Break is a framing error with every data bit and any parity bit low.
  function automatic logic break_det(input logic ferr, input logic [DATA_BITS-1:0] d,
                                     input logic p);
    return ferr & (d == '0) & ((PARITY == 0) | ~p);
  endfunction

  assign w_vote       = maj3(r_smp_a, r_smp_b, r_sync2);
  assign w_sample_pt  = (r_cnt == CNT_HP1);
  assign w_bit_end    = (r_cnt == CNT_LAST);
  assign w_ferr_final = r_ferr_acc | ~w_vote;

  // Two-flop synchroniser for the asynchronous RX pin; idles high.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_RX_Serial;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM: bit timing, majority sampling, shifting and per-frame status.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state    <= S_WAIT_HIGH;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_ferr_acc <= 1'b0;
      r_rx_dv    <= 1'b0;
      r_rx_byte  <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_dv <= 1'b0;
      case (r_state)
        S_WAIT_HIGH: begin
          r_cnt <= '0;
          if (r_sync2) r_state <= S_IDLE;
        end
        S_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (!r_sync2) begin
            r_state    <= S_START;
            r_busy     <= 1'b1;
            r_ferr_acc <= 1'b0;
          end
        end
        S_START, S_DATA, S_PARITY, S_STOP: begin
          r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
          if (r_cnt == CNT_HM1) r_smp_a <= r_sync2;
          if (r_cnt == CNT_H)   r_smp_b <= r_sync2;
          case (r_state)
            S_START: begin
              if (w_sample_pt && w_vote) begin
                // False start: the line recovered before the middle of the start bit.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
              end else if (w_bit_end) begin
                r_state <= S_DATA;
                r_idx   <= '0;
              end
            end
            S_DATA: begin
              if (w_sample_pt) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
              if (w_bit_end) begin
                if (r_idx == IDX_DATA_LAST) begin
                  r_idx   <= '0;
                  r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                end else begin
                  r_idx <= r_idx + 1'b1;
                end
              end
            end
            S_PARITY: begin
              if (w_sample_pt) r_par_bit <= w_vote;
              if (w_bit_end) begin
                r_idx   <= '0;
                r_state <= S_STOP;
              end
            end
            default: begin
              if (w_sample_pt && (r_idx == IDX_STOP_LAST)) begin
                // Final stop decided: deliver now instead of waiting out the bit,
                // so a following start edge is never missed.
                r_rx_dv   <= 1'b1;
                r_rx_byte <= r_shift;
                r_ferr    <= w_ferr_final;
                r_perr    <= parity_err(r_shift, r_par_bit);
                r_brk     <= break_det(w_ferr_final, r_shift, r_par_bit);
                r_busy    <= 1'b0;
                r_cnt     <= '0;
                r_idx     <= '0;
                r_state   <= w_vote ? S_IDLE : S_WAIT_HIGH;
              end else begin
                if (w_sample_pt) r_ferr_acc <= w_ferr_final;
                if (w_bit_end)   r_idx <= r_idx + 1'b1;
              end
            end
          endcase
        end
        default: r_state <= S_WAIT_HIGH;
      endcase
    end
  end

  assign o_RX_DV      = r_rx_dv;
  assign o_RX_Byte    = r_rx_byte;
  assign o_Parity_Err = r_perr;
  assign o_Frame_Err  = r_ferr;
  assign o_Break      = r_brk;
  assign o_RX_Busy    = r_busy;

endmodule
